// File: rtl/matrix_operand_loader_pkg.sv
// Shared constants, types and index helpers for the matrix operand loader
// and its operand register banks.
package matrix_pkg;

    localparam int MAT_N       = 4;
    localparam int FRAME_BEATS = 32;
    localparam int WIDTH       = 16;

    typedef logic [2*WIDTH-1:0] elem_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        HOLD,
        DONE
    } ld_state_t;

    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
    } elem_pos_t;

    // Row-major position of an element within a 4x4 operand.
    function automatic elem_pos_t elem_pos(input logic [3:0] idx);
        elem_pos_t pos;
        pos.row = idx[3:2];
        pos.col = idx[1:0];
        return pos;
    endfunction

endpackage

// File: rtl/matrix_operand_loader_bank.sv
// 4x4 operand register array: one element written per enabled cycle,
// cleared by a synchronous active-low reset.
module operand_bank
    import matrix_pkg::*;
#(
    parameter int W = 32
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                i_we,
    input  logic [1:0]                          i_row,
    input  logic [1:0]                          i_col,
    input  logic [W-1:0]                        i_data,
    output logic [MAT_N-1:0][MAT_N-1:0][W-1:0]  o_mat
);

    logic [MAT_N-1:0][MAT_N-1:0][W-1:0] r_mat;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mat <= '0;
        end else if (i_we) begin
            r_mat[i_row][i_col] <= i_data;
        end
    end

    assign o_mat = r_mat;

endmodule

// File: rtl/matrix_operand_loader.sv
// Streams a 32-beat A/B frame into two operand banks, latches the adder
// config on the first beat, then signals res_valid after a settle hold.
//
//  state  | meaning
//  IDLE   | waiting for the first beat of a frame
//  LOAD_A | receiving A elements 1..15
//  LOAD_B | receiving B elements 0..15
//  HOLD   | operands stable, adder settling
//  DONE   | res_valid high until the consumer takes C
module matrix_operand_loader
    import matrix_pkg::*;
#(
    parameter int width       = 16,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic [2*width-1:0]                           in_data,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [4:0]                                   cfg_m_bit1,
    input  logic [4:0]                                   cfg_m_bit2,
    input  logic                                         cfg_flag,
    input  logic                                         abort,
    output logic [MAT_N-1:0][MAT_N-1:0][2*width-1:0]     A,
    output logic [MAT_N-1:0][MAT_N-1:0][2*width-1:0]     B,
    output logic [4:0]                                   m_bit1,
    output logic [4:0]                                   m_bit2,
    output logic                                         flag,
    output logic                                         busy,
    output logic                                         res_valid,
    input  logic                                         res_ready
);

    localparam logic [4:0] LAST_A    = 5'(FRAME_BEATS / 2 - 1);
    localparam logic [4:0] LAST_BEAT = 5'(FRAME_BEATS - 1);
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    ld_state_t  r_state;
    logic [4:0] r_cnt;
    logic [3:0] r_hold_cnt;
    logic       r_res_valid;
    logic [4:0] r_m_bit1;
    logic [4:0] r_m_bit2;
    logic       r_flag;

    logic       w_loading;
    logic       w_accept;
    logic       w_we_a;
    logic       w_we_b;
    elem_pos_t  w_pos;

    assign w_loading = (r_state == IDLE) || (r_state == LOAD_A) || (r_state == LOAD_B);
    // abort drops a coincident beat, so it must gate the bank writes too.
    assign w_accept  = in_valid && w_loading && !abort;
    assign w_we_a    = w_accept && (r_state != LOAD_B);
    assign w_we_b    = w_accept && (r_state == LOAD_B);
    assign w_pos     = elem_pos(r_cnt[3:0]);

    operand_bank #(.W(2*width)) u_bank_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_we   (w_we_a),
        .i_row  (w_pos.row),
        .i_col  (w_pos.col),
        .i_data (in_data),
        .o_mat  (A)
    );

    operand_bank #(.W(2*width)) u_bank_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_we   (w_we_b),
        .i_row  (w_pos.row),
        .i_col  (w_pos.col),
        .i_data (in_data),
        .o_mat  (B)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_hold_cnt  <= '0;
            r_res_valid <= 1'b0;
            r_m_bit1    <= '0;
            r_m_bit2    <= '0;
            r_flag      <= 1'b0;
        end else if (abort) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_hold_cnt  <= '0;
            r_res_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_m_bit1 <= cfg_m_bit1;
                        r_m_bit2 <= cfg_m_bit2;
                        r_flag   <= cfg_flag;
                        r_cnt    <= 5'd1;
                        r_state  <= LOAD_A;
                    end
                end
                LOAD_A: begin
                    if (in_valid) begin
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == LAST_A) begin
                            r_state <= LOAD_B;
                        end
                    end
                end
                LOAD_B: begin
                    if (in_valid) begin
                        if (r_cnt == LAST_BEAT) begin
                            r_cnt      <= '0;
                            r_hold_cnt <= '0;
                            if (HOLD_CYCLES > 0) begin
                                r_state <= HOLD;
                            end else begin
                                r_state     <= DONE;
                                r_res_valid <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end
                end
                HOLD: begin
                    r_hold_cnt <= r_hold_cnt + 4'd1;
                    if (r_hold_cnt == HOLD_LAST) begin
                        r_state     <= DONE;
                        r_res_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        r_state     <= IDLE;
                        r_res_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_res_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = w_loading;
    assign busy      = (r_state != IDLE);
    assign res_valid = r_res_valid;
    assign m_bit1    = r_m_bit1;
    assign m_bit2    = r_m_bit2;
    assign flag      = r_flag;

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Drives two loaders (hold 2 and hold 0) from one stream and compares every
// cycle against a frame-level reference model.
module tb_matrix_operand_loader;
    import matrix_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_valid;
    logic [4:0]  cfg_m_bit1;
    logic [4:0]  cfg_m_bit2;
    logic        cfg_flag;
    logic        abort;
    logic        res_ready;

    logic                     rdy_h2, rv_h2, busy_h2, fl_h2;
    logic [4:0]               mb1_h2, mb2_h2;
    logic [3:0][3:0][31:0]    a_h2, b_h2;
    logic                     rdy_h0, rv_h0, busy_h0, fl_h0;
    logic [4:0]               mb1_h0, mb2_h0;
    logic [3:0][3:0][31:0]    a_h0, b_h0;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    matrix_operand_loader #(.width(16), .HOLD_CYCLES(2)) dut_h2 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_h2),
        .cfg_m_bit1(cfg_m_bit1), .cfg_m_bit2(cfg_m_bit2), .cfg_flag(cfg_flag), .abort(abort),
        .A(a_h2), .B(b_h2), .m_bit1(mb1_h2), .m_bit2(mb2_h2), .flag(fl_h2), .busy(busy_h2),
        .res_valid(rv_h2), .res_ready(res_ready)
    );

    matrix_operand_loader #(.width(16), .HOLD_CYCLES(0)) dut_h0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_h0),
        .cfg_m_bit1(cfg_m_bit1), .cfg_m_bit2(cfg_m_bit2), .cfg_flag(cfg_flag), .abort(abort),
        .A(a_h0), .B(b_h0), .m_bit1(mb1_h0), .m_bit2(mb2_h0), .flag(fl_h0), .busy(busy_h0),
        .res_valid(rv_h0), .res_ready(res_ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model, index 0 = hold 2, index 1 = hold 0. A frame is just
    // "number of beats taken so far"; after 32 beats a settle wait, then done.
    int          m_beats[2];
    int          m_wait[2];
    bit          m_hold[2];
    bit          m_done[2];
    elem_t       m_a[2][16];
    elem_t       m_b[2][16];
    logic [4:0]  m_mb1[2];
    logic [4:0]  m_mb2[2];
    logic        m_fl[2];

    function automatic int hold_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    task automatic model_step(input int i);
        if (!rst_n) begin
            m_beats[i] = 0; m_wait[i] = 0; m_hold[i] = 0; m_done[i] = 0;
            m_mb1[i] = '0; m_mb2[i] = '0; m_fl[i] = 1'b0;
            for (int e = 0; e < 16; e++) begin
                m_a[i][e] = '0;
                m_b[i][e] = '0;
            end
        end else if (abort) begin
            m_beats[i] = 0; m_wait[i] = 0; m_hold[i] = 0; m_done[i] = 0;
        end else if (m_done[i]) begin
            if (res_ready) m_done[i] = 0;
        end else if (m_hold[i]) begin
            m_wait[i]--;
            if (m_wait[i] == 0) begin
                m_hold[i] = 0;
                m_done[i] = 1;
            end
        end else if (in_valid) begin
            if (m_beats[i] == 0) begin
                m_mb1[i] = cfg_m_bit1; m_mb2[i] = cfg_m_bit2; m_fl[i] = cfg_flag;
            end
            if (m_beats[i] < 16) m_a[i][m_beats[i]] = in_data;
            else                 m_b[i][m_beats[i] - 16] = in_data;
            m_beats[i]++;
            if (m_beats[i] == 32) begin
                m_beats[i] = 0;
                if (hold_of(i) > 0) begin
                    m_hold[i] = 1;
                    m_wait[i] = hold_of(i);
                end else begin
                    m_done[i] = 1;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    task automatic check_dut(input int i, input string nm, input logic rdy, input logic rv,
                             input logic bsy, input logic [4:0] mb1, input logic [4:0] mb2,
                             input logic fl, input logic [3:0][3:0][31:0] a,
                             input logic [3:0][3:0][31:0] b);
        check({nm, " in_ready"}, 64'(rdy), 64'(!(m_hold[i] || m_done[i])));
        check({nm, " res_valid"}, 64'(rv), 64'(m_done[i]));
        check({nm, " busy"}, 64'(bsy), 64'(m_beats[i] != 0 || m_hold[i] || m_done[i]));
        check({nm, " m_bit1"}, 64'(mb1), 64'(m_mb1[i]));
        check({nm, " m_bit2"}, 64'(mb2), 64'(m_mb2[i]));
        check({nm, " flag"}, 64'(fl), 64'(m_fl[i]));
        for (int e = 0; e < 16; e++) begin
            check($sformatf("%s A[%0d]", nm, e), 64'(a[e/4][e%4]), 64'(m_a[i][e]));
            check($sformatf("%s B[%0d]", nm, e), 64'(b[e/4][e%4]), 64'(m_b[i][e]));
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_dut(0, "h2", rdy_h2, rv_h2, busy_h2, mb1_h2, mb2_h2, fl_h2, a_h2, b_h2);
            check_dut(1, "h0", rdy_h0, rv_h0, busy_h0, mb1_h0, mb2_h0, fl_h0, a_h0, b_h0);
        end
    end

    // gap_mode: 0 back-to-back, 1 alternate idle cycle, 2 random idle cycles.
    task automatic send_frame(input bit rnd, input int gap_mode, input int n_beats,
                              input int abort_at, input int cfg_chg_at,
                              input logic [4:0] mb1, input logic [4:0] mb2, input logic fl);
        int lat2;
        int lat0;
        cfg_m_bit1 = mb1; cfg_m_bit2 = mb2; cfg_flag = fl;
        for (int k = 0; k < n_beats; k++) begin
            @(negedge clk);
            if (k == cfg_chg_at) cfg_m_bit1 = 5'd9;
            if (rnd && k > 0 && $urandom_range(0, 3) == 0) begin
                cfg_m_bit2 = 5'($urandom);
                cfg_flag   = 1'($urandom);
            end
            in_data   = rnd ? $urandom : 32'(k + 1);
            in_valid  = 1'b1;
            abort     = (k == abort_at);
            res_ready = (rnd && k != 31) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (k == abort_at) begin
                @(negedge clk);
                in_valid = 1'b0; abort = 1'b0; res_ready = 1'b0;
                return;
            end
            if (k != 31 && (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 2) == 0))) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_data  = $urandom;
            end
        end
        if (n_beats < 32) begin
            @(negedge clk);
            in_valid = 1'b0;
            return;
        end
        lat2 = -1;
        lat0 = -1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (lat2 < 0 && rv_h2) lat2 = e;
            if (lat0 < 0 && rv_h0) lat0 = e;
            if (lat2 >= 0 && lat0 >= 0) break;
        end
        check("latency h2", 64'(lat2), 64'(3));
        check("latency h0", 64'(lat0), 64'(1));
    endtask

    task automatic finish_frame(input int wait_cycles);
        repeat (wait_cycles) begin
            @(negedge clk);
            check("done hold rv h2", 64'(rv_h2), 64'(1));
            check("done hold rdy h2", 64'(rdy_h2), 64'(0));
            check("done hold rv h0", 64'(rv_h0), 64'(1));
            check("done hold rdy h0", 64'(rdy_h0), 64'(0));
        end
        @(negedge clk);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("release rv h2", 64'(rv_h2), 64'(0));
        check("release busy h2", 64'(busy_h2), 64'(0));
        check("release rdy h0", 64'(rdy_h0), 64'(1));
        check("release rv h0", 64'(rv_h0), 64'(0));
    endtask

    initial begin
        rst_n = 1'b0; in_data = '0; in_valid = 1'b0; abort = 1'b0; res_ready = 1'b0;
        cfg_m_bit1 = '0; cfg_m_bit2 = '0; cfg_flag = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("reset rdy", 64'(rdy_h2), 64'(1));
        check("reset busy", 64'(busy_h2), 64'(0));
        check("reset rv", 64'(rv_h2), 64'(0));
        rst_n = 1'b1;

        // Known-data frame, back to back.
        send_frame(1'b0, 0, 32, -1, -1, 5'd3, 5'd7, 1'b1);
        check("t1 A33", 64'(a_h2[3][3]), 64'(16));
        check("t1 B00", 64'(b_h2[0][0]), 64'(17));
        check("t1 B33 h0", 64'(b_h0[3][3]), 64'(32));
        check("t1 m_bit1", 64'(mb1_h2), 64'(3));
        check("t1 m_bit2", 64'(mb2_h2), 64'(7));
        check("t1 flag", 64'(fl_h2), 64'(1));
        check("t1 rdy", 64'(rdy_h2), 64'(0));
        finish_frame(0);

        // Alternating valid, then a long DONE stall.
        send_frame(1'b0, 1, 32, -1, -1, 5'd3, 5'd7, 1'b1);
        check("t2 A12", 64'(a_h2[1][2]), 64'(7));
        check("t2 B31", 64'(b_h2[3][1]), 64'(30));
        finish_frame(10);

        // Abort on beat 20, then a clean random frame.
        send_frame(1'b0, 0, 32, 20, -1, 5'd3, 5'd7, 1'b1);
        check("t4 busy", 64'(busy_h2), 64'(0));
        check("t4 rv", 64'(rv_h2), 64'(0));
        send_frame(1'b1, 0, 32, -1, -1, 5'd4, 5'd5, 1'b0);
        finish_frame(1);

        // Config change mid-frame is ignored; next frame picks it up.
        send_frame(1'b0, 0, 32, -1, 5, 5'd3, 5'd7, 1'b1);
        check("t5 m_bit1 kept", 64'(mb1_h2), 64'(3));
        finish_frame(0);
        send_frame(1'b0, 0, 32, -1, -1, 5'd9, 5'd7, 1'b1);
        check("t5 m_bit1 new", 64'(mb1_h2), 64'(9));
        finish_frame(0);

        // Reset in the middle of LOAD_B.
        send_frame(1'b0, 0, 20, -1, -1, 5'd3, 5'd7, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6 A12", 64'(a_h2[1][2]), 64'(0));
        check("t6 B03", 64'(b_h2[0][3]), 64'(0));
        check("t6 m_bit1", 64'(mb1_h2), 64'(0));
        check("t6 busy", 64'(busy_h2), 64'(0));
        check("t6 rdy", 64'(rdy_h2), 64'(1));
        rst_n = 1'b1;

        // Random frames: gaps, mid-frame cfg noise, aborts, abort-vs-res_ready.
        for (int f = 0; f < 10; f++) begin
            int ab;
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : -1;
            send_frame(1'b1, 2, 32, ab, -1, 5'($urandom), 5'($urandom), 1'($urandom));
            if (ab < 0) begin
                if ($urandom_range(0, 3) == 0) begin
                    @(negedge clk);
                    abort = 1'b1; res_ready = 1'b1;
                    @(negedge clk);
                    abort = 1'b0; res_ready = 1'b0;
                    check("rand abort busy", 64'(busy_h2), 64'(0));
                end else begin
                    finish_frame(int'($urandom_range(0, 5)));
                end
            end
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
